// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream sum accumulator: adder sum width,
// the sum word type and a constant-foldable ceil(log2) helper.
package axis_pkg;

  localparam int SUM_W = 16;

  typedef logic [SUM_W-1:0] sum_t;

  // Number of bits needed to count 0..value-1 (minimum 1 for value <= 2).
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/axis_sum_accumulator_acc_add_sat.sv
// Combinational accumulate step: acc + zero-extended sum word, with carry out.
// Build option AXIS_SUM_ACCUMULATOR_SATURATE_EN clamps the result on carry.
module acc_add_sat
  import axis_pkg::*;
#(
  parameter int OUT_W = 20
) (
  input  logic [OUT_W-1:0] acc_i,
  input  sum_t             data_i,
  output logic [OUT_W-1:0] sum_o,
  output logic             carry_o
);

  logic [OUT_W:0] raw;

  assign raw     = {1'b0, acc_i} + {{(OUT_W + 1 - SUM_W){1'b0}}, data_i};
  assign carry_o = raw[OUT_W];

`ifdef AXIS_SUM_ACCUMULATOR_SATURATE_EN
  // A clamped acc keeps re-clamping on any nonzero beat and holds on zero,
  // so the group total stays at full scale until the group ends.
  assign sum_o = raw[OUT_W] ? {OUT_W{1'b1}} : raw[OUT_W-1:0];
`else
  assign sum_o = raw[OUT_W-1:0];
`endif

endmodule

// File: rtl/axis_sum_accumulator.sv
// Accumulates BEATS input sums into one OUT_W-bit total on a registered
// AXI-Stream master port. Optional macro: AXIS_SUM_ACCUMULATOR_SATURATE_EN.
module axis_sum_accumulator
  import axis_pkg::*;
#(
  parameter int BEATS = 4,
  parameter int OUT_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SUM_W-1:0] s_axis_data,
  input  logic             s_axis_valid,
  output logic             s_axis_ready,
  output logic [OUT_W-1:0] m_axis_data,
  output logic             m_axis_valid,
  input  logic             m_axis_ready,
  output logic             m_axis_ovf
);

  localparam int CNT_W = clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [OUT_W-1:0] m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d;
  logic             m_ovf_q, m_ovf_d;

  logic [OUT_W-1:0] step_sum;
  logic             step_carry;
  logic             last_beat;
  logic             out_free;
  logic             in_fire;

  acc_add_sat #(.OUT_W(OUT_W)) u_add (
    .acc_i   (acc_q),
    .data_i  (s_axis_data),
    .sum_o   (step_sum),
    .carry_o (step_carry)
  );

  assign last_beat    = (cnt_q == LAST_CNT);
  assign out_free     = !m_valid_q || m_axis_ready;
  // Only the final beat needs the output register, so earlier beats never stall.
  assign s_axis_ready = !last_beat || out_free;
  assign in_fire      = s_axis_valid && s_axis_ready;

  // NOTE: every always_comb target gets a default first so no path infers a latch.
  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    m_data_d  = m_data_q;
    m_ovf_d   = m_ovf_q;
    m_valid_d = m_valid_q;

    if (m_valid_q && m_axis_ready) m_valid_d = 1'b0;

    if (in_fire) begin
      if (last_beat) begin
        // Loading here overrides the drain above: back-to-back totals, no bubble.
        m_data_d  = step_sum;
        m_ovf_d   = ovf_q || step_carry;
        m_valid_d = 1'b1;
        acc_d     = '0;
        cnt_d     = '0;
        ovf_d     = 1'b0;
      end else begin
        acc_d = step_sum;
        cnt_d = cnt_q + 1'b1;
        ovf_d = ovf_q || step_carry;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_ovf_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_ovf_q   <= m_ovf_d;
    end
  end

  assign m_axis_data  = m_data_q;
  assign m_axis_valid = m_valid_q;
  assign m_axis_ovf   = m_ovf_q;

endmodule

// File: tb/tb_axis_sum_accumulator.sv
// Self-checking bench: two instances (OUT_W=20 and OUT_W=17) share one stimulus;
// table vectors, hand sequences and a randomized run against a group-sum model.
module tb_axis_sum_accumulator;

  localparam int BEATS = 4;
  localparam int W_A   = 20;
  localparam int W_B   = 17;

  logic          clk;
  logic          rst_n;
  logic [15:0]   s_data;
  logic          s_valid;
  logic          m_ready;
  logic          s_ready_a, s_ready_b;
  logic [W_A-1:0] m_data_a;
  logic [W_B-1:0] m_data_b;
  logic          m_valid_a, m_valid_b;
  logic          m_ovf_a, m_ovf_b;

  int total = 0;
  int bad   = 0;

  axis_sum_accumulator #(.BEATS(BEATS), .OUT_W(W_A)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_axis_data  (s_data),
    .s_axis_valid (s_valid),
    .s_axis_ready (s_ready_a),
    .m_axis_data  (m_data_a),
    .m_axis_valid (m_valid_a),
    .m_axis_ready (m_ready),
    .m_axis_ovf   (m_ovf_a)
  );

  axis_sum_accumulator #(.BEATS(BEATS), .OUT_W(W_B)) u_dut17 (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_axis_data  (s_data),
    .s_axis_valid (s_valid),
    .s_axis_ready (s_ready_b),
    .m_axis_data  (m_data_b),
    .m_axis_valid (m_valid_b),
    .m_axis_ready (m_ready),
    .m_axis_ovf   (m_ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic mr);
    s_valid = v;
    s_data  = d;
    m_ready = mr;
  endtask

  // Expected group total for a given output width, from the plain integer sum.
  function automatic logic [31:0] exp_data(input longint sum, input int w);
    longint maxv;
    maxv = (longint'(1) << w) - 1;
`ifdef AXIS_SUM_ACCUMULATOR_SATURATE_EN
    return (sum > maxv) ? 32'(maxv) : 32'(sum);
`else
    return 32'(sum & maxv);
`endif
  endfunction

  function automatic logic exp_ovf(input longint sum, input int w);
    return sum > ((longint'(1) << w) - 1);
  endfunction

  // ---------------- table vectors ----------------
  typedef struct {
    logic [15:0] data;
    logic        valid;
    logic        mrdy;
    logic        exp_srdy;
    logic        exp_mv;
    logic [19:0] exp_md;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [15:0] d, input logic v, input logic mr,
                     input logic sr, input logic mv, input logic [19:0] md);
    vec_t e;
    e.data = d; e.valid = v; e.mrdy = mr;
    e.exp_srdy = sr; e.exp_mv = mv; e.exp_md = md; e.exp_ovf = 1'b0;
    vecs.push_back(e);
  endtask

  // ---------------- random model state ----------------
  typedef struct {
    logic [31:0] data;
    logic        ovf;
  } tot_t;

  tot_t        q_a[$];
  tot_t        q_b[$];
  longint      acc_m;
  int          cnt_m;
  int          beats_m;
  logic        hold_a, hold_b;
  logic [31:0] prev_a, prev_b;
  logic        prev_ovf_a, prev_ovf_b;

  // One randomized cycle: inputs already driven; sample mid-cycle, compare, advance.
  task automatic rnd_cycle();
    tot_t t;
    logic exp_sr;
    #3;
    exp_sr = (cnt_m != BEATS - 1) || (q_a.size() == 0) || m_ready;
    check("rnd_s_ready", s_ready_a, exp_sr);
    check("rnd_m_valid", m_valid_a, q_a.size() != 0);
    check("rnd_m_valid17", m_valid_b, q_b.size() != 0);
    if (hold_a) begin
      check("rnd_stable", m_data_a, prev_a);
      check("rnd_stable_ovf", m_ovf_a, prev_ovf_a);
    end
    if (hold_b) begin
      check("rnd_stable17", m_data_b, prev_b);
      check("rnd_stable_ovf17", m_ovf_b, prev_ovf_b);
    end
    if (m_valid_a && m_ready && q_a.size() != 0) begin
      t = q_a.pop_front();
      check("rnd_total", m_data_a, t.data);
      check("rnd_ovf", m_ovf_a, t.ovf);
    end
    if (m_valid_b && m_ready && q_b.size() != 0) begin
      t = q_b.pop_front();
      check("rnd_total17", m_data_b, t.data);
      check("rnd_ovf17", m_ovf_b, t.ovf);
    end
    if (s_valid && s_ready_a) begin
      acc_m += longint'(s_data);
      cnt_m++;
      beats_m++;
      if (cnt_m == BEATS) begin
        t.data = exp_data(acc_m, W_A); t.ovf = exp_ovf(acc_m, W_A);
        q_a.push_back(t);
        t.data = exp_data(acc_m, W_B); t.ovf = exp_ovf(acc_m, W_B);
        q_b.push_back(t);
        acc_m = 0;
        cnt_m = 0;
      end
    end
    hold_a = m_valid_a && !m_ready;
    hold_b = m_valid_b && !m_ready;
    prev_a = 32'(m_data_a);
    prev_b = 32'(m_data_b);
    prev_ovf_a = m_ovf_a;
    prev_ovf_b = m_ovf_b;
    tick();
  endtask

  initial begin
    int cycles;
    int drain;

    rst_n = 1'b0;
    drive(1'b0, 16'h0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", m_valid_a, 0);
    check("rst_m_data", m_data_a, 0);
    check("rst_m_ovf", m_ovf_a, 0);
    check("rst_s_ready", s_ready_a, 1);
    rst_n = 1'b1;
    tick();

    // Basic group, streaming, then backpressure with a stalled final beat.
    add(16'd1, 1, 1, 1, 0, 20'd0);
    add(16'd2, 1, 1, 1, 0, 20'd0);
    add(16'd3, 1, 1, 1, 0, 20'd0);
    add(16'd4, 1, 1, 1, 1, 20'd10);
    add(16'd0, 0, 1, 1, 0, 20'd10);
    for (int k = 0; k < 8; k++)
      add(16'h0100, 1, 1, 1, (k % 4) == 3, (k < 3) ? 20'd10 : 20'h400);
    add(16'd0, 0, 1, 1, 0, 20'h400);
    for (int k = 0; k < 3; k++) add(16'd1, 1, 0, 1, 0, 20'h400);
    add(16'd1, 1, 0, 1, 1, 20'd4);
    for (int k = 0; k < 3; k++) add(16'd5, 1, 0, 1, 1, 20'd4);
    for (int k = 0; k < 2; k++) add(16'd5, 1, 0, 0, 1, 20'd4);
    add(16'd5, 1, 1, 1, 1, 20'd20);
    add(16'd0, 0, 1, 1, 0, 20'd20);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].valid, vecs[i].data, vecs[i].mrdy);
      #3;
      check($sformatf("vec%0d_s_ready", i), s_ready_a, vecs[i].exp_srdy);
      tick();
      check($sformatf("vec%0d_m_valid", i), m_valid_a, vecs[i].exp_mv);
      check($sformatf("vec%0d_m_data", i), m_data_a, vecs[i].exp_md);
      check($sformatf("vec%0d_m_ovf", i), m_ovf_a, vecs[i].exp_ovf);
    end

    // Reset mid-group: partial 7+7 must be discarded.
    drive(1'b1, 16'd7, 1'b1); tick();
    drive(1'b1, 16'd7, 1'b1); tick();
    drive(1'b0, 16'd0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_m_data", m_data_a, 0);
    check("midrst_m_valid", m_valid_a, 0);
    repeat (2) tick();
    check("midrst_m_ovf", m_ovf_a, 0);
    check("midrst_s_ready", s_ready_a, 1);
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 16'd5, 1'b1);
      tick();
      if (k < 3) check("postrst_no_valid", m_valid_a, 0);
    end
    drive(1'b0, 16'd0, 1'b1);
    check("postrst_valid", m_valid_a, 1);
    check("postrst_total", m_data_a, 20);

    // Overflow on the 17-bit instance; none on the 20-bit one.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 16'hFFFF, 1'b1);
      tick();
    end
    drive(1'b0, 16'd0, 1'b1);
    check("big_total20", m_data_a, 32'h3FFFC);
    check("big_ovf20", m_ovf_a, 0);
    check("ovf_valid17", m_valid_b, 1);
`ifdef AXIS_SUM_ACCUMULATOR_SATURATE_EN
    check("ovf_total17", m_data_b, 32'h1FFFF);
`else
    check("ovf_total17", m_data_b, 32'h1FFFC);
`endif
    check("ovf_flag17", m_ovf_b, 1);
    tick();
    check("ovf_drained17", m_valid_b, 0);

    // Randomized valid/ready over 1000 accepted beats.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    acc_m = 0; cnt_m = 0; beats_m = 0;
    hold_a = 1'b0; hold_b = 1'b0;
    prev_a = '0; prev_b = '0; prev_ovf_a = 1'b0; prev_ovf_b = 1'b0;
    cycles = 0;
    while (beats_m < 1000 && cycles < 20000) begin
      drive(($urandom % 4) != 0, 16'($urandom), ($urandom % 3) != 0);
      rnd_cycle();
      cycles++;
    end
    check("rnd_beats_done", beats_m, 1000);
    drain = 0;
    while ((q_a.size() != 0 || q_b.size() != 0 || m_valid_a) && drain < 10) begin
      drive(1'b0, 16'd0, 1'b1);
      rnd_cycle();
      drain++;
    end
    check("rnd_queue_empty", q_a.size() + q_b.size(), 0);
    check("rnd_partial", cnt_m, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
